// File: rtl/get_reg_if.sv
// Request/response bundle for the register-name lookup.
// The master drives the request side; the slave (the lookup) returns the result.
interface get_reg_if;
  logic        in_valid;
  logic [5:0]  idx;
  logic        out_valid;
  logic [31:0] name;
  logic        bad_idx;

  modport master (
    output in_valid,
    output idx,
    input  out_valid,
    input  name,
    input  bad_idx
  );

  modport slave (
    input  in_valid,
    input  idx,
    output out_valid,
    output name,
    output bad_idx
  );
endinterface

// File: rtl/get_reg.sv
// RISC-V GPR index to ABI mnemonic lookup, registered with one cycle of latency.
// Names are ASCII, right-justified in 32 bits; indices 32..63 report "?" and bad_idx.
module get_reg (
  input logic      clk,
  input logic      reset_n,
  get_reg_if.slave bus
);

  logic [31:0] name_s;
  logic        bad_s;
  logic        out_valid_r;
  logic [31:0] name_r;
  logic        bad_idx_r;

  // Index 8 deliberately maps to "s0" rather than its "fp" alias.
  function automatic logic [31:0] abi_name(input logic [4:0] i);
    logic [31:0] n;
    case (i)
      5'd0:    n = 32'h7A65_726F;
      5'd1:    n = 32'h0000_7261;
      5'd2:    n = 32'h0000_7370;
      5'd3:    n = 32'h0000_6770;
      5'd4:    n = 32'h0000_7470;
      5'd5:    n = 32'h0000_7430;
      5'd6:    n = 32'h0000_7431;
      5'd7:    n = 32'h0000_7432;
      5'd8:    n = 32'h0000_7330;
      5'd9:    n = 32'h0000_7331;
      5'd10:   n = 32'h0000_6130;
      5'd11:   n = 32'h0000_6131;
      5'd12:   n = 32'h0000_6132;
      5'd13:   n = 32'h0000_6133;
      5'd14:   n = 32'h0000_6134;
      5'd15:   n = 32'h0000_6135;
      5'd16:   n = 32'h0000_6136;
      5'd17:   n = 32'h0000_6137;
      5'd18:   n = 32'h0000_7332;
      5'd19:   n = 32'h0000_7333;
      5'd20:   n = 32'h0000_7334;
      5'd21:   n = 32'h0000_7335;
      5'd22:   n = 32'h0000_7336;
      5'd23:   n = 32'h0000_7337;
      5'd24:   n = 32'h0000_7338;
      5'd25:   n = 32'h0000_7339;
      5'd26:   n = 32'h0073_3130;
      5'd27:   n = 32'h0073_3131;
      5'd28:   n = 32'h0000_7433;
      5'd29:   n = 32'h0000_7434;
      5'd30:   n = 32'h0000_7435;
      5'd31:   n = 32'h0000_7436;
      default: n = 32'h0000_003F;
    endcase
    return n;
  endfunction

  // Combinational decode of the requested index.
  always_comb begin
    name_s = 32'h0000_003F;
    bad_s  = 1'b1;
    if (bus.idx[5] == 1'b0) begin
      name_s = abi_name(bus.idx[4:0]);
      bad_s  = 1'b0;
    end else begin
      name_s = 32'h0000_003F;
      bad_s  = 1'b1;
    end
  end

  // Output registers; idle cycles drop valid but keep the last name and flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      name_r      <= 32'h0000_0000;
      bad_idx_r   <= 1'b0;
    end else if (bus.in_valid) begin
      out_valid_r <= 1'b1;
      name_r      <= name_s;
      bad_idx_r   <= bad_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.name      = name_r;
  assign bus.bad_idx   = bad_idx_r;

endmodule

// File: tb/tb_get_reg.sv
// Directed bench for get_reg: vector table for sweep/out-of-range/idle hold,
// hand-written sequences for reset behaviour.
module tb_get_reg;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  get_reg_if bus ();

  get_reg dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [5:0]  idx;
    logic        exp_valid;
    logic [31:0] exp_name;
    logic        exp_bad;
  } vec_t;

  vec_t  vecs[$];
  string abi[32];

  function automatic logic [31:0] pack_ascii(input string s);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < s.len(); k++) v = {v[23:0], s[k]};
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] n, input logic b);
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    check({tag, ".name"}, bus.name, n);
    check({tag, ".bad_idx"}, {31'd0, bus.bad_idx}, {31'd0, b});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    abi = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
            "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
            "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
            "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};

    // Spot checks of the string packing against literal encodings.
    check("pack.zero", pack_ascii(abi[0]), 32'h7A65_726F);
    check("pack.s11", pack_ascii(abi[27]), 32'h0073_3131);

    // Reset held with a pending request.
    reset_n     = 1'b0;
    bus.in_valid = 1'b1;
    bus.idx      = 6'd5;
    for (int c = 0; c < 3; c++) begin
      step();
      check_out($sformatf("reset%0d", c), 1'b0, 32'h0, 1'b0);
    end
    reset_n = 1'b1;

    // Vector table: full sweep, out-of-range, idle hold.
    for (int i = 0; i < 32; i++)
      vecs.push_back('{1'b1, 6'(i), 1'b1, pack_ascii(abi[i]), 1'b0});
    vecs.push_back('{1'b1, 6'd32, 1'b1, 32'h0000_003F, 1'b1});
    vecs.push_back('{1'b1, 6'd63, 1'b1, 32'h0000_003F, 1'b1});
    vecs.push_back('{1'b1, 6'd2,  1'b1, 32'h0000_7370, 1'b0});
    vecs.push_back('{1'b1, 6'd1,  1'b1, 32'h0000_7261, 1'b0});
    vecs.push_back('{1'b0, 6'd40, 1'b0, 32'h0000_7261, 1'b0});
    vecs.push_back('{1'b0, 6'd9,  1'b0, 32'h0000_7261, 1'b0});

    for (int v = 0; v < vecs.size(); v++) begin
      bus.in_valid = vecs[v].in_valid;
      bus.idx      = vecs[v].idx;
      step();
      check_out($sformatf("vec%0d_idx%0d", v, vecs[v].idx),
                vecs[v].exp_valid, vecs[v].exp_name, vecs[v].exp_bad);
    end

    // Hand-computed encodings from the sweep, re-checked one at a time.
    bus.in_valid = 1'b1;
    bus.idx = 6'd8;  step(); check("lit.idx8", bus.name, 32'h0000_7330);
    bus.idx = 6'd10; step(); check("lit.idx10", bus.name, 32'h0000_6130);
    bus.idx = 6'd31; step(); check("lit.idx31", bus.name, 32'h0000_7436);

    // Out-of-range result, then reset on the same edge as a new request.
    bus.idx = 6'd50; step(); check_out("pre_rst", 1'b1, 32'h0000_003F, 1'b1);
    bus.idx = 6'd4;
    reset_n = 1'b0;
    step();
    check_out("mid_rst", 1'b0, 32'h0, 1'b0);
    bus.in_valid = 1'b0;
    step();
    check_out("mid_rst_hold", 1'b0, 32'h0, 1'b0);

    // First request after release is accepted immediately.
    reset_n      = 1'b1;
    bus.in_valid = 1'b1;
    bus.idx      = 6'd3;
    step();
    check_out("post_rst", 1'b1, 32'h0000_6770, 1'b0);
    bus.in_valid = 1'b0;
    step();
    check_out("post_rst_idle", 1'b0, 32'h0000_6770, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
